// File: rtl/psd_pkg.sv
// Shared project constants: ALU opcodes, ALU FSM state encodings and
// register-bank endpoint encodings, plus the small types used across the slice.
package psd_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MULT = 2'd2;

    // Register-bank endreg encodings: which bank port a write lands on.
    localparam logic [1:0] ENDREG_NONE = 2'd0;
    localparam logic [1:0] ENDREG_A    = 2'd1;
    localparam logic [1:0] ENDREG_B    = 2'd2;
    localparam logic [1:0] ENDREG_AB   = 2'd3;

    typedef struct packed {
        logic [63:0] value;
        logic        carry;
    } alu_out_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the register bank side and seq_alu.
interface seq_alu_if;
    logic        start;
    logic [63:0] opA;
    logic [63:0] opB;
    logic [2:0]  opsel;
    logic [63:0] result;
    logic        busy;
    logic        done;
    logic        zero;
    logic        carry;

    modport master (
        output start, opA, opB, opsel,
        input  result, busy, done, zero, carry
    );

    modport slave (
        input  start, opA, opB, opsel,
        output result, busy, done, zero, carry
    );
endinterface

// File: rtl/seq_alu_mul_iter32.sv
// 32x32 unsigned shift-add multiplier, one multiplier bit per cycle.
// p/ready are combinational so the caller can capture the product on the last step edge.
module mul_iter32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p,
    output logic        ready
);
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (load) begin
            mcand_d  = {32'b0, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            run_d    = (cnt_q != 5'd31);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    // On the final step acc_d already holds the complete product.
    assign p     = acc_d;
    assign ready = run_q && (cnt_q == 5'd31);
endmodule

// File: rtl/seq_alu.sv
// Sequential 64-bit ALU: single-cycle ops go IDLE->EXEC->IDLE, MUL iterates
// 32 cycles in mul_iter32. Operands are latched at the start edge.
module seq_alu
    import psd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    seq_alu_if.slave   bus
);
    logic [1:0]  state_q, state_d;
    logic [63:0] opa_q, opa_d;
    logic [63:0] opb_q, opb_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;

    logic        mul_load;
    logic [63:0] mul_p;
    logic        mul_ready;
    alu_out_t    exec_out;
    logic [64:0] sum_w;
    logic [64:0] diff_w;

    mul_iter32 u_mul (
        .clock (clock),
        .reset (reset),
        .load  (mul_load),
        .a     (bus.opA[31:0]),
        .b     (bus.opB[31:0]),
        .p     (mul_p),
        .ready (mul_ready)
    );

    // Bit 64 of the widened difference is the borrow.
    always_comb begin
        sum_w          = {1'b0, opa_q} + {1'b0, opb_q};
        diff_w         = {1'b0, opa_q} - {1'b0, opb_q};
        exec_out.value = '0;
        exec_out.carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_out.value = sum_w[63:0];
                exec_out.carry = sum_w[64];
            end
            OP_SUB: begin
                exec_out.value = diff_w[63:0];
                exec_out.carry = diff_w[64];
            end
            OP_AND:  exec_out.value = opa_q & opb_q;
            OP_OR:   exec_out.value = opa_q | opb_q;
            OP_XOR:  exec_out.value = opa_q ^ opb_q;
            OP_SHL:  exec_out.value = opa_q << opb_q[5:0];
            OP_SHR:  exec_out.value = opa_q >> opb_q[5:0];
            default: exec_out.value = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        carry_d  = carry_q;
        mul_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    opa_d  = bus.opA;
                    opb_d  = bus.opB;
                    op_d   = bus.opsel;
                    busy_d = 1'b1;
                    if (bus.opsel == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MULT;
                    end else begin
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                result_d = exec_out.value;
                zero_d   = (exec_out.value == 64'd0);
                carry_d  = exec_out.carry;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            ST_MULT: begin
                if (mul_ready) begin
                    result_d = mul_p;
                    zero_d   = (mul_p == 64'd0);
                    carry_d  = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expectations queued at issue, checked on done.
module tb_seq_alu;
    import psd_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        z;
        logic        c;
        int          e0;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_done = 0;
    int   prev_done = 0;
    exp_t sb[$];
    exp_t mon_e;

    seq_alu_if bus ();

    seq_alu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic c);
        logic [64:0] w;
        c = 1'b0;
        case (op)
            OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[63:0]; c = w[64]; end
            OP_SUB: begin r = a - b; c = (a < b); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_MUL: r = 64'(a[31:0]) * 64'(b[31:0]);
            OP_SHL: r = a << b[5:0];
            default: r = a >> b[5:0];
        endcase
    endfunction

    // Drives a request now, returns 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [63:0] r;
        logic c;
        model(op, a, b, r, c);
        bus.start = 1'b1;
        bus.opsel = op;
        bus.opA   = a;
        bus.opB   = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.opA   = ~a;
        bus.opB   = ~b;
        bus.opsel = ~op;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.res = r;
        e.z   = (r == 64'd0);
        e.c   = c;
        e.e0  = cyc;
        e.lat = (op == OP_MUL) ? 32 : 1;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (bus.done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("op=%0d a=%h b=%h -> result=%h zero=%0b carry=%0b cyc=%0d",
                         mon_e.op, mon_e.a, mon_e.b, bus.result, bus.zero, bus.carry, cyc);
                check_eq("result", bus.result, mon_e.res);
                check_eq("zero", 64'(bus.zero), 64'(mon_e.z));
                check_eq("carry", 64'(bus.carry), 64'(mon_e.c));
                check_eq("latency", 64'(cyc - mon_e.e0), 64'(mon_e.lat));
                prev_done = last_done;
                last_done = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        bus.start = 1'b0;
        bus.opA   = '0;
        bus.opB   = '0;
        bus.opsel = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_result", bus.result, 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_zero", 64'(bus.zero), 64'd0);
        check_eq("rst_carry", 64'(bus.carry), 64'd0);

        // First start coincides with the first edge where reset is low.
        reset = 1'b0;
        issue(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_idle();
        check_eq("add_ovf_res", bus.result, 64'd0);
        check_eq("add_ovf_zero", 64'(bus.zero), 64'd1);
        check_eq("add_ovf_carry", 64'(bus.carry), 64'd1);

        issue(OP_SUB, 64'd5, 64'd7);
        wait_idle();
        check_eq("sub_res", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("sub_borrow", 64'(bus.carry), 64'd1);
        check_eq("sub_zero", 64'(bus.zero), 64'd0);

        // MUL with a stray start (and operand churn) while busy.
        issue(OP_MUL, 64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF);
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 100) begin
            busy_cycles++;
            if (busy_cycles == 5) begin
                bus.start = 1'b1;
                bus.opsel = OP_ADD;
                bus.opA   = 64'd1;
                bus.opB   = 64'd1;
            end else if (busy_cycles == 6) begin
                bus.start = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        check_eq("mul_busy_cycles", 64'(busy_cycles), 64'd32);
        wait_idle();
        check_eq("mul_res", bus.result, 64'hFFFF_FFFE_0000_0001);
        check_eq("mul_carry", 64'(bus.carry), 64'd0);
        @(posedge clock);
        #1;
        check_eq("stray_start_ignored", 64'(bus.busy), 64'd0);

        issue(OP_SHL, 64'h8000_0000_0000_0001, 64'd63);
        wait_idle();
        check_eq("shl63", bus.result, 64'h8000_0000_0000_0000);
        issue(OP_SHR, 64'h8000_0000_0000_0001, 64'd63);
        wait_idle();
        check_eq("shr63", bus.result, 64'd1);
        issue(OP_SHL, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFC0);
        wait_idle();
        check_eq("shl0", bus.result, 64'h8000_0000_0000_0001);
        issue(OP_SHR, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0040);
        wait_idle();
        check_eq("shr0", bus.result, 64'h8000_0000_0000_0001);

        // Abort a MUL ten cycles in; it must never report done.
        issue(OP_MUL, 64'd12345, 64'd678);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        void'(sb.pop_back());
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_result", bus.result, 64'd0);
        check_eq("abort_done", 64'(bus.done), 64'd0);
        repeat (40) begin
            @(posedge clock);
            #1;
        end
        issue(OP_ADD, 64'd2, 64'd3);
        wait_idle();
        check_eq("add_after_abort", bus.result, 64'd5);

        // Back-to-back: XOR issued in the done cycle of AND.
        issue(OP_AND, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
        @(posedge clock);
        #1;
        check_eq("b2b_done_and", 64'(bus.done), 64'd1);
        issue(OP_XOR, 64'hAAAA_5555_AAAA_5555, 64'h0F0F_0F0F_0F0F_0F0F);
        @(posedge clock);
        #1;
        check_eq("b2b_done_xor", 64'(bus.done), 64'd1);
        wait_idle();
        @(posedge clock);
        #1;
        check_eq("b2b_gap", 64'(last_done - prev_done), 64'd2);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  op;
            logic [63:0] a;
            logic [63:0] b;
            op = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if (i % 4 == 0) b = 64'(i);
            if (i % 6 == 1) b = a;
            issue(op, a, b);
            wait_idle();
        end

        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have one clock, `clock`; reset is synchronous and active-high, `reset`.
REQ-002 Port list (name, direction, width, meaning) SHALL be:
- `clock`, in, 1: master clock, posedge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: operation request, sampled at posedge.
- `opA`, in, 64: operand A, driven by register-bank output `outA`.
- `opB`, in, 64: operand B, driven by register-bank output `outB`.
- `opsel`, in, 3: operation code.
- `result`, out, 64, registered: feeds register-bank write data `inA`.
- `busy`, out, 1, registered: operation in progress.
- `done`, out, 1, registered: single-cycle pulse, `result` valid.
- `zero`, out, 1, registered: `result` equals 0.
- `carry`, out, 1, registered: carry/borrow of the last ADD/SUB.

Function
REQ-003 `opsel` encodings SHALL be:
- 000 ADD: 64-bit, `carry` = bit 64.
- 001 SUB: `opA`-`opB`, `carry` = borrow.
- 010 AND.
- 011 OR.
- 100 XOR.
- 101 MUL: `opA[31:0]` x `opB[31:0]` unsigned, 64-bit product.
- 110 SHL: `opA` << `opB[5:0]`.
- 111 SHR: logical `opA` >> `opB[5:0]`.
REQ-004 The FSM SHALL have states IDLE, EXEC and MULT.
REQ-005 In IDLE, `start`=1 at edge E0 SHALL latch `opA`, `opB` and `opsel`, and set `busy`=1.
- MUL: next state MULT.
- Any other opcode: next state EXEC.
REQ-006 EXEC SHALL compute the operation and, at edge E1, write `result`, `zero` and `carry`, pulse `done`=1 for one cycle, clear `busy` and return to IDLE.
REQ-007 MULT SHALL use shift-add, one multiplier bit per cycle, with a 5-bit counter running 0..31.
- At edge E32: write `result`, pulse `done`, clear `busy`, return to IDLE.
REQ-008 `start` while `busy`=1 SHALL be ignored; in-flight operands and opcode SHALL remain unchanged.
REQ-009 `start` in the same cycle as `done`=1 SHALL be accepted, since the FSM is already in IDLE; this gives back-to-back single-cycle ops at one result per 2 cycles.
REQ-010 `result`, `zero` and `carry` SHALL hold their values until the next completion.
REQ-011 Logic ops, MUL and shifts SHALL clear `carry`.
REQ-012 Operand changes after E0 SHALL NOT affect the result.
REQ-013 A shift amount of 0 SHALL return `opA`; shifts SHALL never exceed 63 because of the 6-bit field.
REQ-014 ADD/SUB SHALL wrap modulo 2^64.
REQ-015 `zero` SHALL be evaluated on the 64-bit value written to `result`.

Reset
REQ-016 `reset`=1 at any edge SHALL force the following, overriding `start` and any in-flight operation:
- State IDLE.
- `result`=0, `busy`=0, `done`=0, `zero`=0, `carry`=0.
- MUL counter and accumulators cleared.
REQ-017 An aborted operation SHALL NOT produce `done`.
REQ-018 The first `start` SHALL be accepted at the first edge where `reset`=0.

Structure
REQ-019 The opcode constants (3 bits) and FSM state encodings SHALL live in the shared project package `psd_pkg`, alongside the register-bank `endreg` encodings.
REQ-020 The shift-add multiplier SHALL be one sub-module, `mul_iter32`.
- Inputs: `clock`, `reset`, `load`, `a[31:0]`, `b[31:0]`.
- Outputs: `p[63:0]`, `ready`.
- The FSM in `seq_alu` SHALL instantiate it; all other ops stay inline.

Verification
REQ-021 ADD: `opA`=FFFF_FFFF_FFFF_FFFF, `opB`=1 -> `result`=0, `zero`=1, `carry`=1, `done` one cycle after E0.
REQ-022 SUB: `opA`=5, `opB`=7 -> `result`=FFFF_FFFF_FFFF_FFFE, `carry`=1, `zero`=0.
REQ-023 MUL: `opA[31:0]`=FFFF_FFFF, `opB[31:0]`=FFFF_FFFF -> `result`=FFFF_FFFE_0000_0001.
- `busy` high for exactly 32 cycles after E0.
- `done` pulse at E32.
- A `start` during `busy` is ignored.
REQ-024 SHL/SHR: `opA`=8000_0000_0000_0001.
- SHL with `opB[5:0]`=63 -> 8000_0000_0000_0000.
- SHR with `opB[5:0]`=63 -> 1.
- Shift amount 0 -> `opA` unchanged.
REQ-025 `reset` asserted mid-MUL (cycle 10) -> next cycle `busy`=0, `result`=0, no `done`; a fresh ADD 2+3 then yields 5.
REQ-026 Back-to-back: XOR issued in the `done` cycle of a preceding AND -> both results are correct and two `done` pulses occur 2 cycles apart.
